// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes and the mul/div sequencer state type
package alu_pkg;

    localparam logic [4:0] FUNC_MUL  = 5'b10000;
    localparam logic [4:0] FUNC_MULU = 5'b10001;
    localparam logic [4:0] FUNC_MADD = 5'b10010;
    localparam logic [4:0] FUNC_DIV  = 5'b10011;
    localparam logic [4:0] FUNC_MFLO = 5'b10100;
    localparam logic [4:0] FUNC_MFHI = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } seq_state_t;

    function automatic logic is_muldiv_func(input logic [4:0] f);
        return (f == FUNC_MUL) || (f == FUNC_MULU) || (f == FUNC_MADD) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: multiply add-shift or restoring divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_w,
    input  logic [WIDTH-1:0] lo_w,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_sh   = {hi_w, lo_w[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opnd};
        // When the trial subtract succeeds the result is below the divisor, so WIDTH bits suffice.
        div_diff = div_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_nxt = {lo_w[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_w[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative MUL/MULU/MADD/DIV sequencer owning the HI/LO pair
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    input  logic             rd_req,
    input  logic             rd_hi,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    seq_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [4:0]       func;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] hi_w, lo_w, opnd;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic             accept, req_signed, a_neg, b_neg, div0_req, commit, fix_div0, neg_res;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign stall     = rd_req & busy;
    assign rd_data   = rd_hi ? hi : lo;

    assign accept     = req_valid && (state == IDLE) && is_muldiv_func(req_func) && !flush;
    assign req_signed = (req_func != FUNC_MULU);
    assign a_neg      = req_signed & req_a[WIDTH-1];
    assign b_neg      = req_signed & req_b[WIDTH-1];
    assign a_mag      = a_neg ? -req_a : req_a;
    assign b_mag      = b_neg ? -req_b : req_b;
    assign div0_req   = (req_func == FUNC_DIV) && (req_b == '0);

    // Fix-up terms: the engine produced magnitudes, signs are restored here.
    assign neg_res  = sign_a ^ sign_b;
    assign prod     = neg_res ? -{hi_w, lo_w} : {hi_w, lo_w};
    assign quo      = neg_res ? -lo_w : lo_w;
    assign rem      = sign_a ? -hi_w : hi_w;
    assign fix_div0 = (func == FUNC_DIV) && (opnd == '0);
    assign commit   = (state == FIX) && !flush;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (func == FUNC_DIV),
        .hi_w   (hi_w),
        .lo_w   (lo_w),
        .opnd   (opnd),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div0_req ? FIX : RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            func   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_w   <= '0;
            lo_w   <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                func   <= req_func;
                sign_a <= a_neg;
                sign_b <= b_neg;
                hi_w   <= '0;
                // Divide-by-zero skips RUN and reports the raw dividend, so keep it unmodified.
                lo_w   <= div0_req ? req_a : a_mag;
                opnd   <= b_mag;
                cnt    <= CNT_LOAD;
            end else if (state == RUN) begin
                hi_w <= step_hi;
                lo_w <= step_lo;
                cnt  <= cnt - 1'b1;
            end
            if (commit) begin
                case (func)
                    FUNC_MADD: {hi, lo} <= {hi, lo} + prod;
                    FUNC_DIV: begin
                        if (fix_div0) begin
                            hi <= lo_w;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                    default:   {hi, lo} <= prod;
                endcase
            end
        end
    end

endmodule
